seg_decode: RTL

Receive-side decoder for the board's multiplexed seven-segment bus. It samples the active-low `seg`/`sel` lines driven by the display scanner and filters out scan transients. It converts each stable segment code back to a 4-bit digit and reassembles the full 8-digit frame into a 32-bit word. It is used for loopback checking of the display path and for monitoring an external scanned display.

---
 rtl/seg_decode.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seg_decode.sv
// seg_decode: receive-side decoder for the multiplexed seven-segment bus.
// Synchronizes the active-low seg/sel lines, and accepts a digit only after
// the pair has been stable for STABLE_CYCLES samples. It decodes the segment
// code to a nibble and reassembles the 8-digit frame into dsp_data.
module seg_decode #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned FRAME_TIMEOUT = 1_000_000
) (
    input  logic        seg_clk,
    input  logic        seg_rst,
    input  logic [7:0]  seg_in,
    input  logic [7:0]  sel_in,
    output logic [31:0] dsp_data,
    output logic        frame_valid,
    output logic        code_err,
    output logic        link_ok
);

    localparam int unsigned TO_W = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [15:0] ACCEPT_AT = 16'(STABLE_CYCLES - 1);
    // The timeout action lands on the edge where the counter would reach
    // FRAME_TIMEOUT-1, i.e. FRAME_TIMEOUT-1 cycles after the last acceptance.
    localparam logic [TO_W-1:0] TO_FIRE = TO_W'(FRAME_TIMEOUT - 2);

    logic [7:0]      seg_s1, seg_s2, sel_s1, sel_s2;
    logic [7:0]      prev_seg, prev_sel;
    logic [15:0]     stab_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [31:0]     asm_data, asm_next;
    logic [7:0]      mask, mask_next;
    logic            pair_valid, pair_same, accept, to_fire;
    logic [3:0]      digit;
    logic            dig_bad;

    // Two-flop synchronizer for both buses; idle (all-high) out of reset.
    always_ff @(posedge seg_clk) begin
        if (!seg_rst) begin
            seg_s1 <= 8'hFF;
            seg_s2 <= 8'hFF;
            sel_s1 <= 8'hFF;
            sel_s2 <= 8'hFF;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            sel_s1 <= sel_in;
            sel_s2 <= sel_s1;
        end
    end

    // Pair classification and event strobes.
    always_comb begin
        pair_valid = $onehot(~sel_s2);
        pair_same  = (seg_s2 == prev_seg) && (sel_s2 == prev_sel);
        // stab_cnt passes through STABLE_CYCLES-1 once per dwell, and only
        // for a valid pair, so this fires at most once per dwell; prev_* then
        // holds the stable pair being accepted.
        accept     = (stab_cnt == ACCEPT_AT);
        to_fire    = (to_cnt == TO_FIRE);
    end

    // Stability counter: restarts on any change or idle pair, saturates.
    always_ff @(posedge seg_clk) begin
        if (!seg_rst) begin
            prev_seg <= 8'hFF;
            prev_sel <= 8'hFF;
            stab_cnt <= 16'd0;
        end else begin
            prev_seg <= seg_s2;
            prev_sel <= sel_s2;
            if (!pair_valid || !pair_same) begin
                stab_cnt <= 16'd0;
            end else if (stab_cnt != 16'hFFFF) begin
                stab_cnt <= stab_cnt + 16'd1;
            end
        end
    end

    // Segment-code to digit table; unknown codes decode to E and flag an error.
    always_comb begin
        digit   = 4'hE;
        dig_bad = 1'b1;
        case (prev_seg)
            8'hC0: begin digit = 4'h0; dig_bad = 1'b0; end
            8'hF9: begin digit = 4'h1; dig_bad = 1'b0; end
            8'hA4: begin digit = 4'h2; dig_bad = 1'b0; end
            8'hB0: begin digit = 4'h3; dig_bad = 1'b0; end
            8'h99: begin digit = 4'h4; dig_bad = 1'b0; end
            8'h92: begin digit = 4'h5; dig_bad = 1'b0; end
            8'h82: begin digit = 4'h6; dig_bad = 1'b0; end
            8'hF8: begin digit = 4'h7; dig_bad = 1'b0; end
            8'h80: begin digit = 4'h8; dig_bad = 1'b0; end
            8'h90: begin digit = 4'h9; dig_bad = 1'b0; end
            8'hFF: begin digit = 4'hF; dig_bad = 1'b0; end
            default: begin digit = 4'hE; dig_bad = 1'b1; end
        endcase
    end

    // Candidate assembly value: the selected position (sel bit k -> nibble
    // 7-k, so bit 0 is the most significant digit) takes the decoded digit.
    always_comb begin
        asm_next  = asm_data;
        mask_next = mask | ~prev_sel;
        for (int k = 0; k < 8; k++) begin
            if (!prev_sel[k]) begin
                asm_next[28 - 4*k +: 4] = digit;
            end
        end
    end

    // Frame assembly, completion, timeout and output pulses. Acceptance has
    // priority over a coincident timeout.
    always_ff @(posedge seg_clk) begin
        if (!seg_rst) begin
            asm_data    <= 32'd0;
            mask        <= 8'd0;
            to_cnt      <= '0;
            dsp_data    <= 32'd0;
            frame_valid <= 1'b0;
            code_err    <= 1'b0;
            link_ok     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            code_err    <= 1'b0;
            if (accept) begin
                to_cnt   <= '0;
                asm_data <= asm_next;
                code_err <= dig_bad;
                if (mask_next == 8'hFF) begin
                    dsp_data    <= asm_next;
                    frame_valid <= 1'b1;
                    link_ok     <= 1'b1;
                    mask        <= 8'd0;
                end else begin
                    mask <= mask_next;
                end
            end else if (to_fire) begin
                to_cnt  <= '0;
                mask    <= 8'd0;
                link_ok <= 1'b0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule
